// File: rtl/instr_fetch_stage.sv
// Instruction-fetch stage: small writable instruction memory, program counter and
// IDLE/RUN/HALT run control, emitting one registered instruction per cycle to decode.
module instr_fetch_stage #(
    parameter int          ADDR_W    = 4,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stall,
    input  logic              imem_we,
    input  logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_wdata,
    output logic [31:0]       InstrOut,
    output logic              InstrValid,
    output logic [ADDR_W-1:0] PC,
    output logic              Busy,
    output logic              Halted,
    output logic [1:0]        state_dbg
);

    // Handshake: InstrValid qualifies InstrOut for one cycle; there is no ready from
    // decode, so stall is the only back-pressure and freezes PC, InstrOut, InstrValid.
    // While InstrValid is low, InstrOut is forced to zero, which decode treats as a NOP.

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_nxt;
    logic [ADDR_W-1:0] pc_nxt;
    logic [31:0]       instr_nxt;
    logic              valid_nxt;
    logic [31:0]       fetch_word;
    logic              mem_wr;

    logic [31:0] mem [DEPTH];

    assign fetch_word = mem[PC];
    assign mem_wr     = imem_we && (state_q != S_RUN);
    assign state_dbg  = state_q;

    // Memory is deliberately not reset so a program survives a reset.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem[imem_addr] <= imem_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            PC         <= '0;
            InstrOut   <= 32'h0;
            InstrValid <= 1'b0;
            Busy       <= 1'b0;
            Halted     <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            PC         <= pc_nxt;
            InstrOut   <= instr_nxt;
            InstrValid <= valid_nxt;
            Busy       <= (state_nxt == S_RUN);
            Halted     <= (state_nxt == S_HALT);
        end
    end

    always_comb begin
        state_nxt = state_q;
        pc_nxt    = PC;
        instr_nxt = InstrOut;
        valid_nxt = InstrValid;
        unique case (state_q)
            S_IDLE, S_HALT: begin
                instr_nxt = 32'h0;
                valid_nxt = 1'b0;
                if (start) begin
                    state_nxt = S_RUN;
                    pc_nxt    = '0;
                end
            end
            S_RUN: begin
                if (!stall) begin
                    if (fetch_word == HALT_WORD) begin
                        // The halt marker is consumed here and never reaches decode.
                        state_nxt = S_HALT;
                        instr_nxt = 32'h0;
                        valid_nxt = 1'b0;
                    end else begin
                        instr_nxt = fetch_word;
                        valid_nxt = 1'b1;
                        pc_nxt    = PC + ADDR_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
                pc_nxt    = '0;
                instr_nxt = 32'h0;
                valid_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed bench for instr_fetch_stage: program load, stall, wrap, async reset,
// write gating in RUN/HALT and start-ignored-in-RUN.
module tb_instr_fetch_stage;

    localparam int          ADDR_W = 4;
    localparam logic [31:0] HALT   = 32'hFFFF_FFFF;

    logic              clk;
    logic              rst;
    logic              start;
    logic              stall;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [31:0]       InstrOut;
    logic              InstrValid;
    logic [ADDR_W-1:0] PC;
    logic              Busy;
    logic              Halted;
    logic [1:0]        state_dbg;

    logic [31:0] exp_q[$];
    int          tests_run;
    int          tests_failed;

    instr_fetch_stage #(.ADDR_W(ADDR_W), .HALT_WORD(HALT)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stall      (stall),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .InstrOut   (InstrOut),
        .InstrValid (InstrValid),
        .PC         (PC),
        .Busy       (Busy),
        .Halted     (Halted),
        .state_dbg  (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // checking
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // drivers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [ADDR_W-1:0] addr, input logic [31:0] data);
        imem_we    = 1'b1;
        imem_addr  = addr;
        imem_wdata = data;
        tick();
        imem_we    = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Pops one expected word per tick and checks it with the PC that should follow.
    task automatic expect_word(input string tag, input logic [ADDR_W-1:0] pc_exp);
        logic [31:0] w;
        tick();
        w = exp_q.pop_front();
        check({tag, "_instr"}, InstrOut, w);
        check({tag, "_valid"}, 32'(InstrValid), 32'd1);
        check({tag, "_pc"}, 32'(PC), 32'(pc_exp));
    endtask

    task automatic expect_halt(input string tag, input logic [ADDR_W-1:0] pc_exp);
        tick();
        check({tag, "_halted"}, 32'(Halted), 32'd1);
        check({tag, "_busy"}, 32'(Busy), 32'd0);
        check({tag, "_instr"}, InstrOut, 32'h0);
        check({tag, "_valid"}, 32'(InstrValid), 32'd0);
        check({tag, "_pc"}, 32'(PC), 32'(pc_exp));
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst        = 1'b0;
        start      = 1'b0;
        stall      = 1'b0;
        imem_we    = 1'b0;
        imem_addr  = '0;
        imem_wdata = '0;

        // reset state
        #2;
        check("rst_instr", InstrOut, 32'h0);
        check("rst_valid", 32'(InstrValid), 32'd0);
        check("rst_pc", 32'(PC), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_halted", 32'(Halted), 32'd0);
        check("rst_state", 32'(state_dbg), 32'd0);
        tick();
        rst = 1'b1;
        tick();

        // basic program: two words then halt
        write_word(4'd0, 32'h0421_0800);
        write_word(4'd1, 32'h2443_0005);
        write_word(4'd2, HALT);
        check("idle_instr", InstrOut, 32'h0);
        pulse_start();
        check("start_busy", 32'(Busy), 32'd1);
        check("start_valid", 32'(InstrValid), 32'd0);
        check("start_pc", 32'(PC), 32'd0);
        exp_q.push_back(32'h0421_0800);
        exp_q.push_back(32'h2443_0005);
        expect_word("p1_w0", 4'd1);
        expect_word("p1_w1", 4'd2);
        expect_halt("p1_halt", 4'd2);
        tick();
        check("p1_halt_hold_pc", 32'(PC), 32'd2);

        // stall for three cycles after the first word
        pulse_start();
        check("p2_start_pc", 32'(PC), 32'd0);
        exp_q.push_back(32'h0421_0800);
        expect_word("p2_w0", 4'd1);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("p2_stall_instr", InstrOut, 32'h0421_0800);
            check("p2_stall_valid", 32'(InstrValid), 32'd1);
            check("p2_stall_pc", 32'(PC), 32'd1);
            check("p2_stall_busy", 32'(Busy), 32'd1);
        end
        stall = 1'b0;
        exp_q.push_back(32'h2443_0005);
        expect_word("p2_w1", 4'd2);
        expect_halt("p2_halt", 4'd2);

        // full memory without a halt word: PC wraps, start in RUN is ignored
        for (int i = 0; i < 16; i++) begin
            write_word(4'(i), 32'h1000_0000 + 32'(i));
        end
        pulse_start();
        check("p3_start_pc", 32'(PC), 32'd0);
        for (int k = 0; k < 18; k++) begin
            exp_q.push_back(32'h1000_0000 + 32'(k % 16));
            start = (k == 5);
            expect_word("p3_wrap", 4'((k + 1) % 16));
            check("p3_busy", 32'(Busy), 32'd1);
        end
        start = 1'b0;

        // asynchronous reset between edges
        #3;
        rst = 1'b0;
        #1;
        check("arst_instr", InstrOut, 32'h0);
        check("arst_valid", 32'(InstrValid), 32'd0);
        check("arst_pc", 32'(PC), 32'd0);
        check("arst_busy", 32'(Busy), 32'd0);
        #2;
        rst = 1'b1;
        tick();
        check("arst_idle_state", 32'(state_dbg), 32'd0);
        pulse_start();
        exp_q.push_back(32'h1000_0000);
        exp_q.push_back(32'h1000_0001);
        expect_word("arst_mem0", 4'd1);
        expect_word("arst_mem1", 4'd2);

        // write gating: ignored in RUN, applied in HALT together with restart
        rst = 1'b0;
        #1;
        rst = 1'b1;
        tick();
        write_word(4'd0, 32'h0421_0800);
        write_word(4'd1, 32'h2443_0005);
        write_word(4'd2, 32'h0000_1234);
        write_word(4'd3, 32'h0000_0033);
        write_word(4'd4, HALT);
        pulse_start();
        imem_we    = 1'b1;
        imem_addr  = 4'd3;
        imem_wdata = 32'hDEAD_BEEF;
        exp_q.push_back(32'h0421_0800);
        exp_q.push_back(32'h2443_0005);
        exp_q.push_back(32'h0000_1234);
        exp_q.push_back(32'h0000_0033);
        expect_word("p5_w0", 4'd1);
        expect_word("p5_w1", 4'd2);
        expect_word("p5_w2", 4'd3);
        expect_word("p5_w3_unchanged", 4'd4);
        imem_we = 1'b0;
        expect_halt("p5_halt", 4'd4);
        imem_we    = 1'b1;
        imem_addr  = 4'd3;
        imem_wdata = 32'hDEAD_BEEF;
        start      = 1'b1;
        tick();
        start   = 1'b0;
        imem_we = 1'b0;
        check("p5_restart_pc", 32'(PC), 32'd0);
        check("p5_restart_busy", 32'(Busy), 32'd1);
        exp_q.push_back(32'h0421_0800);
        exp_q.push_back(32'h2443_0005);
        exp_q.push_back(32'h0000_1234);
        exp_q.push_back(32'hDEAD_BEEF);
        expect_word("p5r_w0", 4'd1);
        expect_word("p5r_w1", 4'd2);
        expect_word("p5r_w2", 4'd3);
        expect_word("p5r_w3_new", 4'd4);
        expect_halt("p5r_halt", 4'd4);

        // final report
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/instr_fetch_stage.md
Name: instr_fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the stage-1 decode register.
- Holds a small writable instruction memory and a program counter (PC).
- Emits one registered 32-bit instruction word per cycle on InstrOut, which feeds the decode register's InstrIn.
- Run control: start pulse, stall input, and halt on a reserved marker word.

Parameters:
- ADDR_W, 4, PC and memory address width; memory depth = 2**ADDR_W words.
- HALT_WORD, 32'hFFFF_FFFF, instruction value that ends a run; never forwarded downstream.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  single-cycle pulse; begins a run from PC 0.
- stall  input  1  hold PC and InstrOut for this cycle.
- imem_we  input  1  instruction-memory write enable.
- imem_addr  input  ADDR_W  instruction-memory write address.
- imem_wdata  input  32  instruction-memory write data.
- InstrOut  output  32  fetched instruction, registered.
- InstrValid  output  1  InstrOut holds a real fetched instruction.
- PC  output  ADDR_W  address of the next word to fetch.
- Busy  output  1  state is RUN.
- Halted  output  1  state is HALT.

Behaviour:
- Reset (rst=0, asynchronous, takes effect immediately regardless of clk):
  - state=IDLE, PC=0, InstrOut=32'h0, InstrValid=0, Busy=0, Halted=0.
  - Memory contents are not cleared.
  - Reset mid-run aborts the run immediately; outputs go to reset values without waiting for an edge.
- Memory:
  - Read is combinational at mem[PC].
  - Write is synchronous: mem[imem_addr] <= imem_wdata on the edge when imem_we=1 and state is IDLE or HALT.
  - imem_we is ignored in RUN.
- FSM states IDLE, RUN, HALT. Busy and Halted are registered decodes of the state.
- IDLE:
  - start=1 -> RUN, PC<=0.
  - InstrOut stays 0 and InstrValid stays 0.
- RUN, stall=1:
  - PC, InstrOut, InstrValid and state all hold.
  - No halt detection occurs. start is ignored.
- RUN, stall=0, mem[PC]!=HALT_WORD:
  - InstrOut<=mem[PC], InstrValid<=1.
  - PC<=PC+1 modulo 2**ADDR_W: the maximum address wraps to 0 and the run continues.
- RUN, stall=0, mem[PC]==HALT_WORD:
  - state<=HALT, InstrOut<=0, InstrValid<=0.
  - PC holds at the halt-word address.
- RUN: start is ignored.
- HALT:
  - InstrOut=0, InstrValid=0, PC holds.
  - start=1 -> RUN with PC<=0, restarting the program. Memory may be rewritten before the restart.
- Latency: start sampled at edge N -> state RUN after N. mem[0] appears on InstrOut after edge N+1. One word per non-stalled cycle thereafter.
- Zero output when not valid is a NOP for the downstream decode: register 0 destination, opcode 0.
- Simultaneous start and imem_we in IDLE or HALT:
  - The write completes on the same edge that enters RUN.
  - The first fetch uses the updated memory.

Test Plan:
- Reset then load mem[0..2]=32'h0421_0800, 32'h2443_0005, HALT_WORD; pulse start -> InstrOut=32'h0421_0800, then 32'h2443_0005 (InstrValid=1) on consecutive cycles; next edge Halted=1, InstrOut=0, InstrValid=0, PC=2.
- Same program with stall=1 for 3 cycles after the first word -> InstrOut holds 32'h0421_0800 and PC holds 1 for 3 cycles, then resumes with no word lost or duplicated.
- Fill all 16 words with non-halt values, start -> PC sequence 0..15,0,1 (wraps); InstrOut after mem[15] is mem[0]; Busy stays 1.
- Drive rst=0 asynchronously mid-run between clock edges -> InstrOut=0, InstrValid=0, PC=0, Busy=0 immediately; memory contents intact on the next run.
- While in RUN, set imem_we=1 with imem_addr=3 -> mem[3] unchanged; in HALT the same write takes effect, and start re-fetches from PC 0 with the new value.
- start asserted in RUN -> no PC reset and no change to the fetch sequence.
